controle_estados: RTL and testbench

Multicycle sequencer that drives the 4-bit `estado` bus and the opcode-class `tipo` consumed by the control-signal decoder of the RISC-V datapath. It steps each instruction through fetch, decode, execute, optional memory access and writeback, handshaking with instruction and data memories. It also raises the PC/IR write enables and counts retired instructions. It sits between the instruction register and the control decoder, and is the only source of `estado` in the datapath.

---
 rtl/controle_estados.sv | 162 ++++++++++++++++
 tb/tb_controle_estados.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_estados.sv
// controle_estados: multicycle instruction sequencer for the RISC-V datapath.
// It steps each instruction through FETCH, DECODE, EXEC, an optional MEM access and WB,
// handshaking with the instruction and data memories. It also counts retired instructions.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous, active-high reset
//   start_i        leave IDLE and begin fetching
//   halt_i         sampled in WB: 1 returns to IDLE instead of FETCH
//   opcode_i       opcode field of the instruction register
//   imem_ack_i     instruction memory has delivered the word
//   dmem_ready_i   data memory completed the access
//   estado_o       current state code, fed to the control decoder
//   tipo_o         opcode[6:4], latched in DECODE
//   imem_req_o     instruction fetch request
//   ir_write_o     load instruction register (combinational: FETCH && imem_ack_i)
//   dmem_req_o     data memory request
//   dmem_we_o      data memory write (sw)
//   pc_write_o     update program counter
//   instr_count_o  retired-instruction counter
//   erro_o         sticky error flag
module controle_estados #(
  parameter int unsigned TIMEOUT = 15  // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic [6:0]  opcode_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ready_i,
  output logic [3:0]  estado_o,
  output logic [2:0]  tipo_o,
  output logic        imem_req_o,
  output logic        ir_write_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        pc_write_o,
  output logic [31:0] instr_count_o,
  output logic        erro_o
);

  // DECODE and WB codes are decoded downstream and must keep these values.
  typedef enum logic [3:0] {
    StIdle   = 4'b0000,
    StFetch  = 4'b0001,
    StDecode = 4'b0010,
    StExec   = 4'b0100,
    StMem    = 4'b1000,
    StError  = 4'b1110,
    StWb     = 4'b1111
  } state_e;

  localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  tipo_q, tipo_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] count_q, count_d;
  logic        imem_req_q, dmem_req_q, dmem_we_q, pc_write_q, erro_q;

  // Only opcode[6:4] selects the instruction class.
  logic unused_opcode;
  assign unused_opcode = ^opcode_i[3:0];

  always_comb begin
    state_d = state_q;
    tipo_d  = tipo_q;
    wait_d  = wait_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          wait_d  = '0;
        end
      end
      StFetch: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack_i) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StDecode: begin
        tipo_d = opcode_i[6:4];
        if (opcode_i[6:4] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110}) begin
          state_d = StExec;
        end else begin
          state_d = StError;
        end
      end
      StExec: begin
        if (tipo_q == 3'b000 || tipo_q == 3'b010) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ready_i) begin
          state_d = StWb;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StWb: begin
        count_d = count_q + 32'd1;
        wait_d  = '0;
        state_d = halt_i ? StIdle : StFetch;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      tipo_q     <= '0;
      wait_q     <= '0;
      count_q    <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      pc_write_q <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tipo_q     <= tipo_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      imem_req_q <= (state_d == StFetch);
      dmem_req_q <= (state_d == StMem);
      dmem_we_q  <= (state_d == StMem) && (tipo_d == 3'b010);
      pc_write_q <= (state_d == StWb);
      erro_q     <= erro_q | (state_d == StError);
    end
  end

  assign estado_o      = state_q;
  assign tipo_o        = tipo_q;
  assign imem_req_o    = imem_req_q;
  assign ir_write_o    = (state_q == StFetch) && imem_ack_i;
  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign pc_write_o    = pc_write_q;
  assign instr_count_o = count_q;
  assign erro_o        = erro_q;

endmodule

// File: tb/tb_controle_estados.sv
// Bench for controle_estados: each instruction is described at transaction level
// (opcode, fetch wait, memory wait, halt) and expanded into the expected per-cycle
// trace of state code and outputs. Unused handshake inputs carry random noise.
module tb_controle_estados;

  localparam int unsigned TO = 4;

  localparam logic [3:0] IDLE   = 4'b0000;
  localparam logic [3:0] FETCH  = 4'b0001;
  localparam logic [3:0] DECODE = 4'b0010;
  localparam logic [3:0] EXEC   = 4'b0100;
  localparam logic [3:0] MEM    = 4'b1000;
  localparam logic [3:0] ERR    = 4'b1110;
  localparam logic [3:0] WB     = 4'b1111;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic        imem_ack_i = 1'b0;
  logic        dmem_ready_i = 1'b0;
  logic [3:0]  estado_o;
  logic [2:0]  tipo_o;
  logic        imem_req_o, ir_write_o, dmem_req_o, dmem_we_o, pc_write_o, erro_o;
  logic [31:0] instr_count_o;

  controle_estados #(.TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .opcode_i     (opcode_i),
    .imem_ack_i   (imem_ack_i),
    .dmem_ready_i (dmem_ready_i),
    .estado_o     (estado_o),
    .tipo_o       (tipo_o),
    .imem_req_o   (imem_req_o),
    .ir_write_o   (ir_write_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .pc_write_o   (pc_write_o),
    .instr_count_o(instr_count_o),
    .erro_o       (erro_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 0;
  bit          dead;

  // {estado, imem_req, ir_write, dmem_req, dmem_we, pc_write, erro}
  logic [9:0] obs;
  assign obs = {estado_o, imem_req_o, ir_write_o, dmem_req_o, dmem_we_o, pc_write_o, erro_o};

  function automatic logic [9:0] pk(logic [3:0] st, logic ireq, logic irw, logic dreq,
                                    logic dwe, logic pcw, logic er);
    return {st, ireq, irw, dreq, dwe, pcw, er};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Check the outputs of the current cycle at the falling edge, then move past the next edge.
  task automatic cyc(string tag, logic [9:0] want);
    @(negedge clk);
    chk(tag, {22'b0, obs}, {22'b0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack_i   = 1'($urandom);
    dmem_ready_i = 1'($urandom);
    start_i      = 1'($urandom);
    halt_i       = 1'($urandom);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    noise();
    start_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_out", {22'b0, obs}, {22'b0, pk(IDLE, 0, 0, 0, 0, 0, 0)});
    chk("reset_count", instr_count_o, 32'd0);
    chk("reset_tipo", {29'b0, tipo_o}, 32'd0);
    @(posedge clk);
    #1;
    reset_i   = 1'b0;
    exp_count = 0;
    dead      = 1'b0;
  endtask

  task automatic idle_wait();
    noise();
    start_i = 1'b0;
    cyc("idle", pk(IDLE, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle_start();
    noise();
    start_i = 1'b1;
    cyc("idle_start", pk(IDLE, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic err_hold(int n);
    for (int k = 0; k < n; k++) begin
      chk("err_count", instr_count_o, exp_count);
      noise();
      cyc("err_hold", pk(ERR, 0, 0, 0, 0, 0, 1));
    end
  endtask

  // One instruction, starting in its FETCH entry cycle. fw/mw are the no-ack cycles
  // before the ack; fw or mw >= TO means the memory never answers in time.
  task automatic run_instr(logic [6:0] op, int fw, int mw, bit hlt, bit abort_mem);
    logic [2:0] cls;
    logic       we;
    cls  = op[6:4];
    we   = (cls == 3'b010);
    dead = 1'b0;
    opcode_i = op;
    for (int i = 0; i < 16; i++) begin
      noise();
      if (i < fw) begin
        imem_ack_i = 1'b0;
        cyc("fetch_wait", pk(FETCH, 1, 0, 0, 0, 0, 0));
        if (i == int'(TO) - 1) begin
          dead = 1'b1;
          break;
        end
      end else begin
        imem_ack_i = 1'b1;
        cyc("fetch_ack", pk(FETCH, 1, 1, 0, 0, 0, 0));
        break;
      end
    end
    if (dead) begin
      noise();
      cyc("fetch_timeout", pk(ERR, 0, 0, 0, 0, 0, 1));
      return;
    end
    noise();
    chk("decode_count", instr_count_o, exp_count);
    cyc("decode", pk(DECODE, 0, 0, 0, 0, 0, 0));
    opcode_i = 7'($urandom);  // tipo must come from the latched value
    if (!(cls inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110})) begin
      dead = 1'b1;
      noise();
      cyc("illegal", pk(ERR, 0, 0, 0, 0, 0, 1));
      return;
    end
    noise();
    chk("exec_tipo", {29'b0, tipo_o}, {29'b0, cls});
    cyc("exec", pk(EXEC, 0, 0, 0, 0, 0, 0));
    if (cls == 3'b000 || cls == 3'b010) begin
      for (int j = 0; j < 16; j++) begin
        noise();
        if (abort_mem) begin
          reset_i = 1'b1;
          cyc("mem_abort", pk(MEM, 0, 0, 1, we, 0, 0));
          return;
        end
        if (j < mw) begin
          dmem_ready_i = 1'b0;
          cyc("mem_wait", pk(MEM, 0, 0, 1, we, 0, 0));
          if (j == int'(TO) - 1) begin
            dead = 1'b1;
            break;
          end
        end else begin
          dmem_ready_i = 1'b1;
          cyc("mem_ready", pk(MEM, 0, 0, 1, we, 0, 0));
          break;
        end
      end
      if (dead) begin
        noise();
        cyc("mem_timeout", pk(ERR, 0, 0, 0, 0, 0, 1));
        return;
      end
    end
    noise();
    halt_i = hlt;
    chk("wb_tipo", {29'b0, tipo_o}, {29'b0, cls});
    cyc("wb", pk(WB, 0, 0, 0, 0, 1, 0));
    exp_count = exp_count + 1;
    chk("post_wb_count", instr_count_o, exp_count);
  endtask

  logic [2:0] legal_cls [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110};

  initial begin
    dead = 1'b0;
    // Reset held two cycles, then idle with start low.
    do_reset();
    idle_wait();
    idle_wait();
    idle_start();

    // add: FETCH, DECODE, EXEC, WB, then FETCH of the next instruction.
    run_instr(7'b0110011, 0, 0, 1'b0, 1'b0);
    // sw with ready on the third MEM cycle.
    run_instr(7'b0100011, 0, 2, 1'b0, 1'b0);
    // lw with halt in WB returns to IDLE.
    run_instr(7'b0000011, 0, 0, 1'b1, 1'b0);
    chk("halt_count", instr_count_o, 32'd3);
    idle_wait();
    idle_start();
    // Fetch ack arriving in the last allowed cycle, branch class.
    run_instr(7'b1100011, int'(TO) - 1, 0, 1'b0, 1'b0);
    // lw whose ready arrives in the last allowed MEM cycle.
    run_instr(7'b0000011, 0, int'(TO) - 1, 1'b0, 1'b0);

    // Random legal instruction stream.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      bit         h;
      op = {legal_cls[$urandom_range(0, 4)], 4'($urandom)};
      h  = ($urandom_range(0, 7) == 0);
      run_instr(op, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), h, 1'b0);
      if (h) begin
        idle_wait();
        idle_start();
      end
    end

    // Fetch timeout: no ack for TO cycles, then ERROR is sticky.
    run_instr(7'b0010011, int'(TO), 0, 1'b0, 1'b0);
    chk("fetch_timeout_dead", {31'b0, dead}, 32'd1);
    err_hold(4);

    // Data memory timeout on a sw.
    do_reset();
    idle_start();
    run_instr(7'b0100011, 0, int'(TO), 1'b0, 1'b0);
    err_hold(2);

    // Illegal class 101: no pc_write, count unchanged.
    do_reset();
    idle_start();
    run_instr(7'b0010011, 0, 0, 1'b0, 1'b0);
    run_instr(7'b1010011, 0, 0, 1'b0, 1'b0);
    err_hold(3);
    chk("illegal_count", instr_count_o, 32'd1);

    // Reset during MEM of a lw.
    do_reset();
    idle_start();
    run_instr(7'b0110011, 0, 0, 1'b0, 1'b0);
    run_instr(7'b0000011, 0, 2, 1'b0, 1'b1);
    reset_i = 1'b0;
    exp_count = 0;
    chk("mid_reset_count", instr_count_o, 32'd0);
    chk("mid_reset_tipo", {29'b0, tipo_o}, 32'd0);
    idle_wait();
    idle_start();
    run_instr(7'b0010011, 0, 0, 1'b1, 1'b0);
    idle_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
